hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl_pkg.sv | 53 +++++
 rtl/hazard_stall_ctrl_mdu_busy_timer.sv | 46 ++++
 rtl/hazard_stall_ctrl.sv | 91 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types, timing constants and the register-hazard helper for the
// decode-stage stall controller of the 5-stage MIPS pipeline.
package hazard_stall_ctrl_pkg;

    // Tuse: cycles until D needs an operand. Tnew: cycles after entering E
    // until the result can be forwarded.
    localparam logic [1:0] T_BRANCH = 2'd0;
    localparam logic [1:0] T_ALU    = 2'd1;
    localparam logic [1:0] T_STORE  = 2'd2;
    localparam logic [1:0] T_LOAD   = 2'd2;
    localparam logic [1:0] T_JAL    = 2'd0;

    // Default MDU latencies, counted after the mult/div leaves E.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    // MDU tag carried alongside the E entry.
    typedef struct packed {
        logic start;
        logic div;
    } md_tag_t;

    // Scoreboard entry for the instruction currently in E.
    typedef struct packed {
        logic [4:0] reg_addr;
        logic [1:0] tnew;
        md_tag_t    md;
    } e_entry_t;

    // Scoreboard entry for the instruction currently in M.
    typedef struct packed {
        logic [4:0] reg_addr;
        logic [1:0] tnew;
    } m_entry_t;

    // A source operand stalls when a producer in E or M writes it and its
    // result is not ready by the time D needs it. $0 is never a hazard.
    function automatic logic reg_hazard(
        input logic [4:0] r,
        input logic       use_r,
        input logic [1:0] tuse,
        input e_entry_t   e,
        input m_entry_t   m
    );
        logic e_hit;
        logic m_hit;
        e_hit = (r == e.reg_addr) && (e.tnew > tuse);
        m_hit = (r == m.reg_addr) && (m.tnew > tuse);
        return use_r && (r != 5'd0) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_timer.sv
// Countdown modelling the multi-cycle mult/div unit. The count is loaded when
// a mult/div sits in E and runs down to zero; the unit is busy while a
// mult/div is in E or the count is non-zero.
module mdu_busy_timer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  md_tag_t e_md_i,
    output logic    busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load on a mult/div in E, otherwise count down and hold at 0.
    // A reload mid-count cannot happen because a new mult/div is stalled in D
    // while the unit is busy.
    always_comb begin
        cnt_d = cnt_q;
        if (e_md_i.start) begin
            cnt_d = e_md_i.div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register, abandoned immediately on reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy as soon as the mult/div reaches E, until the count has drained.
    always_comb begin
        busy_o = e_md_i.start || (cnt_q != '0);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/hazard controller beside the decode stage. Tracks destination
// register and Tnew for E and M, plus MDU occupancy, and decides every cycle
// whether the instruction in D advances or is held while a bubble enters E.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_use_rs,
    input  logic       d_use_rt,
    input  logic [1:0] d_Tuse_rs,
    input  logic [1:0] d_Tuse_rt,
    input  logic [4:0] d_WriteReg,
    input  logic [1:0] d_Tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       PC_en,
    output logic       IFID_en,
    output logic       IDEX_clear,
    output logic       mdu_busy
);

    e_entry_t e_q;
    e_entry_t e_d;
    m_entry_t m_q;
    m_entry_t m_d;

    logic hz_rs;
    logic hz_rt;
    logic md_stall;
    logic stall;

    // MDU occupancy; the E entry's tag drives both the load and the busy flag.
    mdu_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_mdu_busy_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .e_md_i  (e_q.md),
        .busy_o  (mdu_busy)
    );

    // Stall decision, purely combinational from the scoreboard and D.
    always_comb begin
        hz_rs    = reg_hazard(d_rs, d_use_rs, d_Tuse_rs, e_q, m_q);
        hz_rt    = reg_hazard(d_rt, d_use_rt, d_Tuse_rt, e_q, m_q);
        md_stall = d_md_use && mdu_busy;
        stall    = hz_rs || hz_rt || md_stall;
    end

    // Scoreboard advance: E ages into M with Tnew decayed; E takes D or a bubble.
    always_comb begin
        m_d.reg_addr = e_q.reg_addr;
        m_d.tnew     = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
        e_d          = '0;
        if (!stall) begin
            e_d.reg_addr = d_WriteReg;
            e_d.tnew     = d_Tnew;
            e_d.md.start = d_md_start;
            e_d.md.div   = d_md_div;
        end
    end

    // Scoreboard registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
        end
    end

    // Pipeline controls: hold PC and IF/ID, bubble ID/EX while stalled.
    always_comb begin
        PC_en      = !stall;
        IFID_en    = !stall;
        IDEX_clear = stall;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Each cycle the observed controls
// {PC_en, IFID_en, IDEX_clear, mdu_busy} are compared with hand-computed
// values; multi-cycle sequences are queued in exp_q and drained per cycle.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic [1:0] d_Tuse_rs;
    logic [1:0] d_Tuse_rt;
    logic [4:0] d_WriteReg;
    logic [1:0] d_Tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;
    logic       PC_en;
    logic       IFID_en;
    logic       IDEX_clear;
    logic       mdu_busy;

    logic [3:0] outv;
    logic [3:0] exp_q[$];
    int         pass_cnt;
    int         total_cnt;

    // Expected control words {PC_en, IFID_en, IDEX_clear, mdu_busy}
    localparam logic [3:0] GO      = 4'b1100;
    localparam logic [3:0] GO_BUSY = 4'b1101;
    localparam logic [3:0] HOLD    = 4'b0010;
    localparam logic [3:0] HOLD_MD = 4'b0011;

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_use_rs   (d_use_rs),
        .d_use_rt   (d_use_rt),
        .d_Tuse_rs  (d_Tuse_rs),
        .d_Tuse_rt  (d_Tuse_rt),
        .d_WriteReg (d_WriteReg),
        .d_Tnew     (d_Tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .PC_en      (PC_en),
        .IFID_en    (IFID_en),
        .IDEX_clear (IDEX_clear),
        .mdu_busy   (mdu_busy)
    );

    assign outv = {PC_en, IFID_en, IDEX_clear, mdu_busy};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b (PC_en IFID_en IDEX_clear mdu_busy)",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(
        input logic [4:0] rs, input logic [4:0] rt,
        input logic use_rs, input logic use_rt,
        input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
        input logic [4:0] wr, input logic [1:0] tnew,
        input logic md_start, input logic md_div, input logic md_use
    );
        d_rs       = rs;
        d_rt       = rt;
        d_use_rs   = use_rs;
        d_use_rt   = use_rt;
        d_Tuse_rs  = tuse_rs;
        d_Tuse_rt  = tuse_rt;
        d_WriteReg = wr;
        d_Tnew     = tnew;
        d_md_start = md_start;
        d_md_div   = md_div;
        d_md_use   = md_use;
    endtask

    task automatic set_nop();
        set_instr(5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Drain E, M and the MDU countdown with NOPs.
    task automatic flush();
        set_nop();
        repeat (12) step();
    endtask

    // Check one queued expectation per cycle with D held constant.
    task automatic run_expect(input string tag);
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            check($sformatf("%s[%0d]", tag, idx), outv, exp_q.pop_front());
            idx++;
            step();
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        set_nop();
        #3;
        check("reset_state", outv, GO);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // lw $8 then beq $8: two stall cycles, released on the third
        set_instr(5'd1, 5'd0, 1'b1, 1'b0, T_ALU, T_ALU, 5'd8, T_LOAD, 1'b0, 1'b0, 1'b0);
        #1 check("lw8_issue", outv, GO);
        step();
        set_instr(5'd8, 5'd0, 1'b1, 1'b0, T_BRANCH, T_BRANCH, 5'd0, T_JAL, 1'b0, 1'b0, 1'b0);
        #1;
        exp_q.push_back(HOLD);
        exp_q.push_back(HOLD);
        exp_q.push_back(GO);
        run_expect("lw8_beq");
        flush();

        // Same register field but operand not read: no stall
        set_instr(5'd1, 5'd0, 1'b1, 1'b0, T_ALU, T_ALU, 5'd8, T_LOAD, 1'b0, 1'b0, 1'b0);
        step();
        set_instr(5'd8, 5'd8, 1'b0, 1'b0, T_BRANCH, T_BRANCH, 5'd0, T_JAL, 1'b0, 1'b0, 1'b0);
        #1 check("lw8_unused_src", outv, GO);
        flush();

        // addu $9 -> addu reading $9 forwards; beq two behind sees M decayed
        set_instr(5'd1, 5'd2, 1'b1, 1'b1, T_ALU, T_ALU, 5'd9, T_ALU, 1'b0, 1'b0, 1'b0);
        #1 check("addu9_issue", outv, GO);
        step();
        set_instr(5'd9, 5'd0, 1'b1, 1'b0, T_ALU, T_ALU, 5'd10, T_ALU, 1'b0, 1'b0, 1'b0);
        #1 check("addu_fwd", outv, GO);
        step();
        set_instr(5'd9, 5'd0, 1'b1, 1'b0, T_BRANCH, T_BRANCH, 5'd0, T_JAL, 1'b0, 1'b0, 1'b0);
        #1 check("beq_m_decayed", outv, GO);
        flush();

        // beq right behind addu $9: one stall cycle
        set_instr(5'd1, 5'd2, 1'b1, 1'b1, T_ALU, T_ALU, 5'd9, T_ALU, 1'b0, 1'b0, 1'b0);
        step();
        set_instr(5'd9, 5'd0, 1'b1, 1'b0, T_BRANCH, T_BRANCH, 5'd0, T_JAL, 1'b0, 1'b0, 1'b0);
        #1;
        exp_q.push_back(HOLD);
        exp_q.push_back(GO);
        run_expect("addu_beq");
        flush();

        // lw $0 then beq on $0: never a hazard
        set_instr(5'd1, 5'd0, 1'b1, 1'b0, T_ALU, T_ALU, 5'd0, T_LOAD, 1'b0, 1'b0, 1'b0);
        step();
        set_instr(5'd0, 5'd0, 1'b1, 1'b1, T_BRANCH, T_BRANCH, 5'd0, T_JAL, 1'b0, 1'b0, 1'b0);
        #1 check("zero_reg", outv, GO);
        flush();

        // lw $5 then sw storing $5 (Tuse_rt=2): forwarded in time
        set_instr(5'd1, 5'd0, 1'b1, 1'b0, T_ALU, T_ALU, 5'd5, T_LOAD, 1'b0, 1'b0, 1'b0);
        step();
        set_instr(5'd29, 5'd5, 1'b1, 1'b1, T_ALU, T_STORE, 5'd0, T_JAL, 1'b0, 1'b0, 1'b0);
        #1 check("lw_sw_data", outv, GO);
        flush();

        // $7 produced by loads in both E and M, beq reads it through rt
        set_instr(5'd1, 5'd0, 1'b1, 1'b0, T_ALU, T_ALU, 5'd7, T_LOAD, 1'b0, 1'b0, 1'b0);
        step();
        set_instr(5'd1, 5'd0, 1'b1, 1'b0, T_ALU, T_ALU, 5'd7, T_LOAD, 1'b0, 1'b0, 1'b0);
        #1 check("lw7_second", outv, GO);
        step();
        set_instr(5'd0, 5'd7, 1'b0, 1'b1, T_BRANCH, T_BRANCH, 5'd0, T_JAL, 1'b0, 1'b0, 1'b0);
        #1;
        exp_q.push_back(HOLD);
        exp_q.push_back(HOLD);
        exp_q.push_back(GO);
        run_expect("em_both_rt");
        flush();

        // mult then mflo: busy 6 cycles, mflo held 6 and released on the 7th
        set_instr(5'd4, 5'd5, 1'b1, 1'b1, T_ALU, T_ALU, 5'd0, T_JAL, 1'b1, 1'b0, 1'b1);
        #1 check("mult_issue", outv, GO);
        step();
        set_instr(5'd0, 5'd0, 1'b0, 1'b0, T_ALU, T_ALU, 5'd2, T_ALU, 1'b0, 1'b0, 1'b1);
        #1;
        repeat (6) exp_q.push_back(HOLD_MD);
        exp_q.push_back(GO);
        run_expect("mult_mflo");
        flush();

        // Non-MDU instruction while the MDU is busy is not held
        set_instr(5'd4, 5'd5, 1'b1, 1'b1, T_ALU, T_ALU, 5'd0, T_JAL, 1'b1, 1'b0, 1'b1);
        step();
        set_instr(5'd1, 5'd2, 1'b1, 1'b1, T_ALU, T_ALU, 5'd3, T_ALU, 1'b0, 1'b0, 1'b0);
        #1 check("mdu_indep", outv, GO_BUSY);
        flush();

        // div then mflo: busy 11 cycles
        set_instr(5'd4, 5'd5, 1'b1, 1'b1, T_ALU, T_ALU, 5'd0, T_JAL, 1'b1, 1'b1, 1'b1);
        #1 check("div_issue", outv, GO);
        step();
        set_instr(5'd0, 5'd0, 1'b0, 1'b0, T_ALU, T_ALU, 5'd2, T_ALU, 1'b0, 1'b0, 1'b1);
        #1;
        repeat (11) exp_q.push_back(HOLD_MD);
        exp_q.push_back(GO);
        run_expect("div_mflo");
        flush();

        // mult, then asynchronous reset mid-cycle three cycles later
        set_instr(5'd4, 5'd5, 1'b1, 1'b1, T_ALU, T_ALU, 5'd0, T_JAL, 1'b1, 1'b0, 1'b1);
        step();
        set_nop();
        step();
        step();
        #1 check("pre_reset_busy", outv, GO_BUSY);
        #2 reset = 1'b1;
        set_instr(5'd0, 5'd0, 1'b0, 1'b0, T_ALU, T_ALU, 5'd2, T_ALU, 1'b0, 1'b0, 1'b1);
        #1 check("async_reset", outv, GO);
        #1 reset = 1'b0;
        #1 check("post_reset", outv, GO);
        step();
        set_nop();
        #1 check("after_reset_edge", outv, GO);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
